// File: rtl/edge_pkg.sv
// ---------------------------------------------------------------------------
// edge_pkg
//   Shared definitions for the streaming Sobel edge detector.
//   - PW_DEF      : default pixel / edge width
//   - edge_mode_e : output mode encoding (magnitude or binary threshold map)
//   - GW(pw)      : width of a signed Sobel gradient for pw-bit pixels
//   - MW(pw)      : width of the unsigned |Gx|+|Gy| magnitude
// ---------------------------------------------------------------------------
package edge_pkg;

   localparam int PW_DEF = 5;

   typedef enum logic {
      EDGE_MAG = 1'b0,
      EDGE_THR = 1'b1
   } edge_mode_e;

   // A 1-2-1 weighted column difference spans +/-(4*(2^pw-1)), which needs
   // pw+2 magnitude bits plus a sign bit.
   function automatic int GW(input int pw);
      return pw + 3;
   endfunction

   // Sum of two gradient magnitudes; one extra bit keeps it overflow-free.
   function automatic int MW(input int pw);
      return pw + 4;
   endfunction

endpackage

// File: rtl/sobel_lane.sv
// ---------------------------------------------------------------------------
// sobel_lane
//   One output row of the Sobel detector. Takes the 3x3 neighbourhood of an
//   interior pixel (left/middle/right column, rows a=r-1, b=r, c=r+1),
//   registers Gx/Gy (pipeline stage S1) and derives the edge value
//   combinationally from those registers.
//   The centre pixel has zero weight in both kernels, so it is not a port.
// Ports
//   clk, reset        : clock, asynchronous active-low reset
//   en                : capture new gradients into S1
//   l_a, l_b, l_c     : left (oldest) column, rows a/b/c
//   m_a, m_c          : middle column, rows a/c
//   r_a, r_b, r_c     : right (newest) column, rows a/b/c
//   mode, thresh      : output mode and threshold (frame-latched upstream)
//   edge_val          : saturated magnitude or all-ones/zero threshold bit
// ---------------------------------------------------------------------------
module sobel_lane
   import edge_pkg::*;
#(
   parameter int PW = PW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [PW-1:0] l_a,
   input  logic [PW-1:0] l_b,
   input  logic [PW-1:0] l_c,
   input  logic [PW-1:0] m_a,
   input  logic [PW-1:0] m_c,
   input  logic [PW-1:0] r_a,
   input  logic [PW-1:0] r_b,
   input  logic [PW-1:0] r_c,
   input  edge_mode_e    mode,
   input  logic [PW-1:0] thresh,
   output logic [PW-1:0] edge_val
);

   localparam int GWID = GW(PW);
   localparam int MWID = MW(PW);

   // Weighted sums are non-negative; their difference is kept as a
   // two's-complement bit pattern of GWID bits (the true result always fits).
   logic [GWID-1:0] sum_r, sum_l, sum_c, sum_a;
   logic [GWID-1:0] gx_next, gy_next;
   logic [GWID-1:0] gx, gy;
   logic [GWID-1:0] abs_x, abs_y;
   logic [MWID-1:0] mag;

   always_comb begin
      sum_r   = GWID'(r_a) + (GWID'(r_b) << 1) + GWID'(r_c);
      sum_l   = GWID'(l_a) + (GWID'(l_b) << 1) + GWID'(l_c);
      sum_c   = GWID'(l_c) + (GWID'(m_c) << 1) + GWID'(r_c);
      sum_a   = GWID'(l_a) + (GWID'(m_a) << 1) + GWID'(r_a);
      gx_next = sum_r - sum_l;
      gy_next = sum_c - sum_a;
   end

   // S1: gradient registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gx <= '0;
         gy <= '0;
      end else if (en) begin
         gx <= gx_next;
         gy <= gy_next;
      end
   end

   always_comb begin
      abs_x    = gx[GWID-1] ? (~gx + 1'b1) : gx;
      abs_y    = gy[GWID-1] ? (~gy + 1'b1) : gy;
      mag      = MWID'(abs_x) + MWID'(abs_y);
      edge_val = '0;
      if (mode == EDGE_THR) begin
         edge_val = (mag >= MWID'(thresh)) ? {PW{1'b1}} : {PW{1'b0}};
      end else begin
         edge_val = (mag > MWID'({PW{1'b1}})) ? {PW{1'b1}} : mag[PW-1:0];
      end
   end

endmodule

// File: rtl/edge_stream_sobel.sv
// ---------------------------------------------------------------------------
// edge_stream_sobel
//   Streaming column-wise Sobel edge detector. Each valid cycle delivers one
//   column of NCH vertically adjacent pixels; the block keeps a 3-column
//   window and produces NCH-2 edge values (interior rows) per column from
//   the third column of a frame onwards.
// Ports
//   clk, reset   : clock, asynchronous active-low reset
//   in_valid     : pixel_in holds a column this cycle
//   load_end     : with in_valid, this column closes the frame
//   mode, thresh : output mode / threshold, latched on a frame's first column
//   pixel_in     : row r at [r*PW +: PW], r=0 is the top row
//   edge_out     : lane j (row j+1) at [j*PW +: PW]
//   readable     : edge_out carries a new result this cycle
//   frame_done   : one-cycle pulse when the last column's result has drained
//
// Handshake: there is no ready/backpressure. A column is accepted in every
// cycle in_valid is high; readable is a pure one-cycle qualifier two cycles
// after the accepted column, and edge_out holds its last value otherwise.
// ---------------------------------------------------------------------------
module edge_stream_sobel
   import edge_pkg::*;
#(
   parameter int PW  = PW_DEF,
   parameter int NCH = 5,
   parameter int CW  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic                  load_end,
   input  logic                  mode,
   input  logic [PW-1:0]         thresh,
   input  logic [NCH*PW-1:0]     pixel_in,
   output logic [(NCH-2)*PW-1:0] edge_out,
   output logic                  readable,
   output logic                  frame_done
);

   localparam int NL = NCH - 2;

   // The window is the two previously accepted columns plus the incoming
   // one: S1 captures gradients in the same cycle the column is accepted,
   // which is what gives a two-register latency to edge_out.
   logic [NCH*PW-1:0] win_l;   // column k-2 when column k arrives
   logic [NCH*PW-1:0] win_m;   // column k-1
   logic [CW-1:0]     col_cnt; // index of the next column in this frame
   edge_mode_e        mode_q;
   logic [PW-1:0]     thresh_q;
   logic              v1;      // S1 holds a result
   logic              end1;    // S1 holds the frame's last column
   logic              has_result;
   logic [NL*PW-1:0]  lane_edge;

   assign has_result = (col_cnt >= CW'(2));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_l    <= '0;
         win_m    <= '0;
         col_cnt  <= '0;
         mode_q   <= EDGE_MAG;
         thresh_q <= '0;
      end else if (in_valid) begin
         win_l <= win_m;
         win_m <= pixel_in;
         if (col_cnt == '0) begin
            mode_q   <= edge_mode_e'(mode);
            thresh_q <= thresh;
         end
         // Clearing on the last column lets the next frame start next cycle
         // without ever pairing its columns with this frame's window.
         if (load_end) begin
            col_cnt <= '0;
         end else if (col_cnt != '1) begin
            col_cnt <= col_cnt + 1'b1;
         end
      end
   end

   for (genvar j = 0; j < NL; j++) begin : g_lane
      sobel_lane #(.PW(PW)) u_lane (
         .clk      (clk),
         .reset    (reset),
         .en       (in_valid),
         .l_a      (win_l[j*PW +: PW]),
         .l_b      (win_l[(j+1)*PW +: PW]),
         .l_c      (win_l[(j+2)*PW +: PW]),
         .m_a      (win_m[j*PW +: PW]),
         .m_c      (win_m[(j+2)*PW +: PW]),
         .r_a      (pixel_in[j*PW +: PW]),
         .r_b      (pixel_in[(j+1)*PW +: PW]),
         .r_c      (pixel_in[(j+2)*PW +: PW]),
         .mode     (mode_q),
         .thresh   (thresh_q),
         .edge_val (lane_edge[j*PW +: PW])
      );
   end

   // S2 plus the qualifier pipes. mode_q may be re-latched by a new frame in
   // the same edge that S2 captures the old frame's last result; S2 samples
   // the pre-edge value, so the old frame keeps its own mode.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v1         <= 1'b0;
         end1       <= 1'b0;
         readable   <= 1'b0;
         frame_done <= 1'b0;
         edge_out   <= '0;
      end else begin
         v1         <= in_valid && has_result;
         end1       <= in_valid && load_end;
         readable   <= v1;
         frame_done <= end1;
         if (v1) begin
            edge_out <= lane_edge;
         end
      end
   end

endmodule
